mem_access: RTL and testbench

- MEM-stage memory engine. Consumes the load/save request that the execute stage places in EX_MEM and performs it over a byte-wide synchronous RAM port, one byte per cycle.
- Asserts a stall while busy and delivers the write-back triple (modify_flag/modify_address/modify_data) to MEM_WB.
- Non-memory instructions pass through with one-cycle latency.

---
 rtl/mem_access.sv | 183 ++++++++++++++++++
 tb/tb_mem_access.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// MEM-stage engine: runs EX_MEM loads/stores over a byte-wide synchronous RAM, one byte per cycle.
// Latency: pass-through 1 cycle; load N+3 cycles, store N+2 cycles to write-back; stall_req held while busy.
module mem_access #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  save,
   input  logic [31:0]           sl_reg_address,
   input  logic [31:0]           sl_data,
   input  logic [2:0]            sl_data_length,
   input  logic                  sl_data_signed,
   input  logic                  modify_flag,
   input  logic [4:0]            modify_address,
   input  logic [31:0]           modify_data,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_wr,
   output logic [7:0]            ram_dout,
   input  logic [7:0]            ram_din,
   output logic                  stall_req,
   output logic                  wb_modify_flag,
   output logic [4:0]            wb_modify_address,
   output logic [31:0]           wb_modify_data
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_READ      = 3'd1;
   localparam logic [2:0] S_READ_WAIT = 3'd2;
   localparam logic [2:0] S_WRITE     = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic        rd_vld_q, rd_vld_d;
   logic [1:0]  rd_idx_q, rd_idx_d;
   logic [31:0] base_q;
   logic [2:0]  nbytes_q;
   logic        signed_q, is_load_q, mflag_q;
   logic [4:0]  mdest_q;
   logic        wb_flag_q, wb_flag_d;
   logic [4:0]  wb_addr_q, wb_addr_d;
   logic [31:0] wb_data_q, wb_data_d;

   logic        accept, last_byte, busy;
   logic [2:0]  nbytes_dec;
   logic [31:0] byte_addr, dout_shift, ext_data;

   assign accept    = (state_q == S_IDLE) && (load || save);
   assign last_byte = ({1'b0, cnt_q} == (nbytes_q - 3'd1));
   assign byte_addr = base_q + {30'd0, cnt_q};
   assign dout_shift = data_q >> {cnt_q, 3'b000};
   assign busy = (state_q == S_READ) || (state_q == S_READ_WAIT) || (state_q == S_WRITE);

   // Only lengths 1 and 2 are narrow; anything else is treated as a word.
   always_comb begin
      case (sl_data_length)
         3'd1:    nbytes_dec = 3'd1;
         3'd2:    nbytes_dec = 3'd2;
         default: nbytes_dec = 3'd4;
      endcase
   end

   always_comb begin
      case (nbytes_q)
         3'd1:    ext_data = {{24{signed_q & data_q[7]}}, data_q[7:0]};
         3'd2:    ext_data = {{16{signed_q & data_q[15]}}, data_q[15:0]};
         default: ext_data = data_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      rd_vld_d  = 1'b0;
      rd_idx_d  = cnt_q;
      wb_flag_d = wb_flag_q;
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
      // RAM data lags its address by one cycle, so capture is driven by a delayed index.
      if (rd_vld_q) begin
         case (rd_idx_q)
            2'd0:    data_d[7:0]   = ram_din;
            2'd1:    data_d[15:8]  = ram_din;
            2'd2:    data_d[23:16] = ram_din;
            default: data_d[31:24] = ram_din;
         endcase
      end
      case (state_q)
         S_IDLE: begin
            if (load || save) begin
               state_d   = load ? S_READ : S_WRITE;
               cnt_d     = 2'd0;
               data_d    = load ? 32'd0 : sl_data;
               wb_flag_d = 1'b0;
            end else begin
               wb_flag_d = modify_flag;
               wb_addr_d = modify_address;
               wb_data_d = modify_data;
            end
         end
         S_READ: begin
            rd_vld_d = 1'b1;
            if (last_byte) begin
               state_d = S_READ_WAIT;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_READ_WAIT: state_d = S_DONE;
         S_WRITE: begin
            if (last_byte) begin
               state_d = S_DONE;
               cnt_d   = 2'd0;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (is_load_q) begin
               wb_flag_d = mflag_q;
               wb_addr_d = mdest_q;
               wb_data_d = ext_data;
            end else begin
               wb_flag_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 2'd0;
         data_q    <= 32'd0;
         rd_vld_q  <= 1'b0;
         rd_idx_q  <= 2'd0;
         base_q    <= 32'd0;
         nbytes_q  <= 3'd0;
         signed_q  <= 1'b0;
         is_load_q <= 1'b0;
         mflag_q   <= 1'b0;
         mdest_q   <= 5'd0;
         wb_flag_q <= 1'b0;
         wb_addr_q <= 5'd0;
         wb_data_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         rd_vld_q  <= rd_vld_d;
         rd_idx_q  <= rd_idx_d;
         wb_flag_q <= wb_flag_d;
         wb_addr_q <= wb_addr_d;
         wb_data_q <= wb_data_d;
         if (accept) begin
            base_q    <= sl_reg_address;
            nbytes_q  <= nbytes_dec;
            signed_q  <= sl_data_signed;
            is_load_q <= load;
            mflag_q   <= modify_flag;
            mdest_q   <= modify_address;
         end
      end
   end

   // RAM-side and stall outputs are gated by reset so an aborted store stops writing immediately.
   assign stall_req = !rst && (busy || accept);
   assign ram_wr    = !rst && (state_q == S_WRITE);
   assign ram_addr  = (!rst && ((state_q == S_READ) || (state_q == S_WRITE)))
                      ? byte_addr[ADDR_WIDTH-1:0] : '0;
   assign ram_dout  = ram_wr ? dout_shift[7:0] : 8'd0;

   assign wb_modify_flag    = wb_flag_q;
   assign wb_modify_address = wb_addr_q;
   assign wb_modify_data    = wb_data_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed table, mid-store reset sequence, and random traffic vs a byte-array model.
module tb_mem_access;
   localparam int AW = 17;
   localparam int MEMSZ = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          load, save, sl_data_signed, modify_flag;
   logic [31:0]   sl_reg_address, sl_data, modify_data;
   logic [2:0]    sl_data_length;
   logic [4:0]    modify_address;
   logic [AW-1:0] ram_addr;
   logic          ram_wr;
   logic [7:0]    ram_dout, ram_din;
   logic          stall_req, wb_modify_flag;
   logic [4:0]    wb_modify_address;
   logic [31:0]   wb_modify_data;

   logic [7:0] mem     [MEMSZ];
   logic [7:0] ref_mem [MEMSZ];

   int checks = 0;
   int errors = 0;

   mem_access #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .load(load), .save(save),
      .sl_reg_address(sl_reg_address), .sl_data(sl_data),
      .sl_data_length(sl_data_length), .sl_data_signed(sl_data_signed),
      .modify_flag(modify_flag), .modify_address(modify_address), .modify_data(modify_data),
      .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
      .stall_req(stall_req), .wb_modify_flag(wb_modify_flag),
      .wb_modify_address(wb_modify_address), .wb_modify_data(wb_modify_data)
   );

   always #5 clk = ~clk;

   // Synchronous byte RAM: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (ram_wr) mem[ram_addr] <= ram_dout;
      ram_din <= mem[ram_addr];
   end

   typedef struct {
      logic        ld, sv;
      logic [31:0] addr, data;
      logic [2:0]  len;
      logic        sgn, mf;
      logic [4:0]  ma;
      logic [31:0] md;
      logic        xf;
      logic [4:0]  xa;
      logic [31:0] xd;
   } txn_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      load = 1'b0; save = 1'b0;
      sl_reg_address = $urandom; sl_data = $urandom;
      sl_data_length = 3'($urandom); sl_data_signed = 1'($urandom);
      modify_flag = 1'($urandom); modify_address = 5'($urandom); modify_data = $urandom;
   endtask

   function automatic int nbytes(input logic [2:0] len);
      return (len == 3'd1) ? 1 : (len == 3'd2) ? 2 : 4;
   endfunction

   function automatic logic [AW-1:0] baddr(input logic [31:0] base, input int k);
      logic [31:0] a;
      a = base + 32'(k);
      return a[AW-1:0];
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] base, input int n, input logic sgn);
      longint v;
      v = 0;
      for (int k = 0; k < n; k++) v += longint'(ref_mem[baddr(base, k)]) << (8 * k);
      if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1)))
         v += (longint'(1) << 32) - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   // Starts at posedge+1 of the request cycle; returns at posedge+1 after the write-back is checked.
   task automatic run_txn(input txn_t t, input string nm);
      int n;
      logic is_mem, is_ld;
      logic [31:0] exp_byte;
      n = nbytes(t.len);
      is_ld  = t.ld;
      is_mem = t.ld | t.sv;
      load = t.ld; save = t.sv;
      sl_reg_address = t.addr; sl_data = t.data; sl_data_length = t.len;
      sl_data_signed = t.sgn; modify_flag = t.mf; modify_address = t.ma; modify_data = t.md;
      @(negedge clk);
      chk({nm, ".stall_T"}, 32'(stall_req), 32'(is_mem));
      chk({nm, ".wr_T"}, 32'(ram_wr), 32'd0);
      step();
      idle_inputs();
      if (is_mem) begin
         for (int k = 0; k < n; k++) begin
            @(negedge clk);
            exp_byte = is_ld ? 32'd0 : ((t.data >> (8 * k)) & 32'hFF);
            chk({nm, ".stall_acc"}, 32'(stall_req), 32'd1);
            chk({nm, ".ram_wr"}, 32'(ram_wr), 32'(!is_ld));
            chk({nm, ".ram_addr"}, 32'(ram_addr), 32'(baddr(t.addr, k)));
            chk({nm, ".ram_dout"}, 32'(ram_dout), exp_byte);
            chk({nm, ".bubble"}, 32'(wb_modify_flag), 32'd0);
            step();
         end
         if (is_ld) begin
            @(negedge clk);
            chk({nm, ".stall_wait"}, 32'(stall_req), 32'd1);
            chk({nm, ".wr_wait"}, 32'(ram_wr), 32'd0);
            step();
         end
         @(negedge clk);
         chk({nm, ".stall_done"}, 32'(stall_req), 32'd0);
         chk({nm, ".wr_done"}, 32'(ram_wr), 32'd0);
         chk({nm, ".addr_done"}, 32'(ram_addr), 32'd0);
         step();
         if (!is_ld)
            for (int k = 0; k < n; k++) ref_mem[baddr(t.addr, k)] = 8'((t.data >> (8 * k)) & 32'hFF);
      end
      @(negedge clk);
      chk({nm, ".wb_flag"}, 32'(wb_modify_flag), 32'(t.xf));
      if (t.xf) begin
         chk({nm, ".wb_addr"}, 32'(wb_modify_address), 32'(t.xa));
         chk({nm, ".wb_data"}, wb_modify_data, t.xd);
      end
      step();
   endtask

   txn_t tbl[11];
   txn_t r;
   logic [7:0] b;
   int bad;

   initial begin
      for (int i = 0; i < MEMSZ; i++) begin
         b = 8'($urandom);
         mem[i] = b; ref_mem[i] = b;
      end
      mem[32'h100] = 8'h80; mem[32'h200] = 8'h11; mem[32'h201] = 8'h22;
      mem[32'h202] = 8'h33; mem[32'h203] = 8'h44; mem[32'h302] = 8'h55;
      mem[32'h303] = 8'h66; mem[32'h1FFFF] = 8'h34; mem[0] = 8'h92;
      for (int i = 0; i < 4; i++) mem[32'h400 + i] = 8'h5A;
      foreach (mem[i]) ref_mem[i] = mem[i];

      //          ld    sv    addr          data           len   sgn   mf    ma     md             xf    xa     xd
      tbl[0]  = '{1'b0, 1'b0, 32'h0,        32'h0,         3'd0, 1'b0, 1'b1, 5'd5,  32'h1234,     1'b1, 5'd5,  32'h0000_1234};
      tbl[1]  = '{1'b1, 1'b0, 32'h100,      32'h0,         3'd1, 1'b1, 1'b1, 5'd3,  32'h0,        1'b1, 5'd3,  32'hFFFF_FF80};
      tbl[2]  = '{1'b1, 1'b0, 32'h100,      32'h0,         3'd1, 1'b0, 1'b1, 5'd3,  32'h0,        1'b1, 5'd3,  32'h0000_0080};
      tbl[3]  = '{1'b1, 1'b0, 32'h200,      32'h0,         3'd4, 1'b1, 1'b1, 5'd7,  32'h0,        1'b1, 5'd7,  32'h4433_2211};
      tbl[4]  = '{1'b0, 1'b1, 32'h300,      32'hAABBCCDD,  3'd2, 1'b0, 1'b1, 5'd8,  32'h0,        1'b0, 5'd0,  32'h0};
      tbl[5]  = '{1'b1, 1'b0, 32'h300,      32'h0,         3'd4, 1'b0, 1'b1, 5'd9,  32'h0,        1'b1, 5'd9,  32'h6655_CCDD};
      tbl[6]  = '{1'b1, 1'b0, 32'h1FFFF,    32'h0,         3'd2, 1'b0, 1'b1, 5'd10, 32'h0,        1'b1, 5'd10, 32'h0000_9234};
      tbl[7]  = '{1'b1, 1'b0, 32'h1FFFF,    32'h0,         3'd2, 1'b1, 1'b1, 5'd11, 32'h0,        1'b1, 5'd11, 32'hFFFF_9234};
      tbl[8]  = '{1'b1, 1'b0, 32'h200,      32'h0,         3'd3, 1'b1, 1'b1, 5'd12, 32'h0,        1'b1, 5'd12, 32'h4433_2211};
      tbl[9]  = '{1'b1, 1'b0, 32'h200,      32'h0,         3'd1, 1'b0, 1'b0, 5'd13, 32'h0,        1'b0, 5'd0,  32'h0};
      tbl[10] = '{1'b1, 1'b1, 32'h203,      32'hFFFFFFFF,  3'd1, 1'b1, 1'b1, 5'd14, 32'h0,        1'b1, 5'd14, 32'h0000_0044};

      rst = 1'b1;
      idle_inputs();
      load = 1'b0; save = 1'b0;
      step(); step();
      @(negedge clk);
      chk("reset.stall", 32'(stall_req), 32'd0);
      chk("reset.ram_wr", 32'(ram_wr), 32'd0);
      chk("reset.ram_addr", 32'(ram_addr), 32'd0);
      chk("reset.ram_dout", 32'(ram_dout), 32'd0);
      chk("reset.wb_flag", 32'(wb_modify_flag), 32'd0);
      chk("reset.wb_addr", 32'(wb_modify_address), 32'd0);
      chk("reset.wb_data", wb_modify_data, 32'd0);
      step();
      rst = 1'b0;

      for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

      // Reset two cycles into a word store: only byte 0 may land.
      load = 1'b0; save = 1'b1; sl_reg_address = 32'h400; sl_data = 32'hDEADBEEF;
      sl_data_length = 3'd4; sl_data_signed = 1'b0; modify_flag = 1'b1;
      modify_address = 5'd1; modify_data = 32'h0;
      step();
      idle_inputs();
      @(negedge clk);
      chk("rstmid.wr_b0", 32'(ram_wr), 32'd1);
      chk("rstmid.addr_b0", 32'(ram_addr), 32'h400);
      chk("rstmid.dout_b0", 32'(ram_dout), 32'hEF);
      step();
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid.wr", 32'(ram_wr), 32'd0);
      chk("rstmid.stall", 32'(stall_req), 32'd0);
      chk("rstmid.addr", 32'(ram_addr), 32'd0);
      chk("rstmid.dout", 32'(ram_dout), 32'd0);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid.post_stall", 32'(stall_req), 32'd0);
      chk("rstmid.post_wb_flag", 32'(wb_modify_flag), 32'd0);
      chk("rstmid.post_wb_data", wb_modify_data, 32'd0);
      chk("rstmid.mem400", 32'(mem[32'h400]), 32'hEF);
      chk("rstmid.mem401", 32'(mem[32'h401]), 32'h5A);
      ref_mem[32'h400] = 8'hEF;
      step();
      r = '{1'b0, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b1, 5'd21, 32'hCAFE0001, 1'b1, 5'd21, 32'hCAFE0001};
      run_txn(r, "rstmid.idle");

      for (int i = 0; i < 300; i++) begin
         r.ld = ($urandom_range(0, 2) == 0);
         r.sv = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 3))
            0:       r.addr = $urandom;
            1:       r.addr = 32'h1FFFC + 32'($urandom_range(0, 3));
            2:       r.addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
            default: r.addr = 32'h500 + 32'($urandom_range(0, 63));
         endcase
         r.data = $urandom; r.len = 3'($urandom); r.sgn = 1'($urandom);
         r.mf = 1'($urandom); r.ma = 5'($urandom); r.md = $urandom;
         r.xa = r.ma;
         if (r.ld) begin
            r.xf = r.mf;
            r.xd = model_load(r.addr, nbytes(r.len), r.sgn);
         end else if (r.sv) begin
            r.xf = 1'b0; r.xd = 32'h0;
         end else begin
            r.xf = r.mf; r.xd = r.md;
         end
         run_txn(r, $sformatf("rnd%0d", i));
      end

      bad = 0;
      for (int i = 0; i < MEMSZ; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("ram_image", 32'(bad), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
